mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one unified single-port memory between the CPU instruction-fetch port and the load/store data port. Each port sees a req/gnt/rvalid handshake. The block serialises accesses onto a memory port with `m_req`/`m_ready`/`m_rvalid`. A watchdog returns an error response if memory never completes.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `TIMEOUT_CYCLES`, 255, max cycles in ISSUE+WAIT before error; must be ≥2
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  ADDR_W  fetch address
- `i_gnt`  out  1  one-cycle grant pulse
- `i_rvalid`  out  1  one-cycle response pulse
- `i_rdata`  out  DATA_W  fetch data, valid with `i_rvalid`
- `i_err`  out  1  timeout flag, valid with `i_rvalid`
- `d_req`  in  1  data request; held with `d_addr`/`d_we`/`d_wdata` until `d_gnt`
- `d_addr`  in  ADDR_W  data address
- `d_we`  in  DATA_W/8  byte write enables; 0 = load, nonzero = store
- `d_wdata`  in  DATA_W  store data
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`  out  1/1/DATA_W/1  as for the I port
- `m_req`  out  1  memory request, held until `m_ready`
- `m_addr`, `m_we`, `m_wdata`  out  ADDR_W/DATA_W/8/DATA_W  registered request fields
- `m_ready`  in  1  memory accepts request this cycle
- `m_rvalid`  in  1  completion; loads and stores both complete with one pulse
- `m_rdata`  in  DATA_W  read data with `m_rvalid`

## Operation
- FSM has four states:
  - IDLE: if any req, pick a winner (combinational) and assert that port's gnt this cycle. Latch addr/we/wdata into `m_*` (I port: `m_we`=0, `m_wdata`=0). Go to ISSUE.
  - ISSUE: `m_req`=1, `m_*` stable. On `m_ready`, go to WAIT.
  - WAIT: `m_req`=0. On `m_rvalid`, register `m_rdata`, set err=0, go to RESP.
  - RESP: the owner's rvalid=1 with registered rdata/err for exactly one cycle. Go to IDLE. No grant is issued in RESP.
- Timeout:
  - The counter clears on entering ISSUE and increments every cycle in ISSUE/WAIT.
  - If it equals `TIMEOUT_CYCLES-1` and no advance/completion occurs that cycle, go to RESP with err=1, rdata=0, and `m_req` dropped.
- `m_rvalid` is ignored outside WAIT; late completions after a timeout are discarded.
- The non-owner's rvalid/gnt stay 0. A losing request stays pending and is served in a later IDLE.
- Default priority: D port always beats I port on contention.
- Reset at any point:
  - State returns to IDLE, the in-flight transaction is dropped, and the timeout counter clears.
  - All outputs are 0: gnts, rvalids, errs, rdatas, `m_req`, `m_addr`, `m_we`, `m_wdata`.

## Timing
- Request seen in IDLE at cycle 0: gnt in cycle 0, `m_req` from cycle 1.
- Zero-wait memory (`m_ready` in cycle 1, `m_rvalid` in cycle 2): rvalid in cycle 3. Minimum latency is 3 cycles.
- Throughput: at most one transaction per 4 cycles (IDLE→ISSUE→WAIT→RESP).
- Every output is a register or a pure decode of state/registers. The exception is the gnts: they are combinational from state==IDLE plus the req inputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_d` flag records the winner and updates at each grant; reset value is 0.
  - On contention, the port not granted last wins, so the first contention after reset goes to D.
  - A single requester is always granted.
- Undefined: fixed D-over-I priority and no `last_d` register.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the owner enum (OWN_I, OWN_D)
  - the default width/timeout constants
- Sub-module `mem_arb_pick`: combinational winner selection from `i_req`, `d_req` and `last_d` (ignored without `MEM_ARB_RR_EN`). It outputs the winner's owner and a valid flag.

## Test plan
- Reset: hold `reset` 2 cycles with all reqs high → every output is 0. The first grant comes in the first cycle after deassertion.
- Fetch `i_addr`=0x0000_0040, memory with zero wait returning 0xDEADBEEF → `i_gnt` in cycle 0, `m_addr`=0x40 and `m_we`=0 in cycle 1, `i_rvalid` with 0xDEADBEEF and `i_err`=0 in cycle 3.
- `i_req` and a store (`d_addr`=0x100, `d_we`=4'b1111, `d_wdata`=0x12345678) together in cycle 0:
  - Fixed priority: `d_gnt` first, `m_we`=1111, `m_wdata`=0x12345678; `i_gnt` in the IDLE after `d_rvalid`.
  - `MEM_ARB_RR_EN`: repeat the contention; the second contention grants I.
- Backpressure: `m_ready` low for 3 cycles → `m_req`, `m_addr`, `m_we`, `m_wdata` held constant. Completion then proceeds normally.
- Timeout with `TIMEOUT_CYCLES`=8 and `m_ready` never asserted:
  - D load granted in cycle 0, ISSUE cycles 1–8.
  - `d_rvalid`=1, `d_err`=1, `d_rdata`=0 in cycle 9.
  - A later `m_rvalid` produces no response.
- `reset` pulsed in WAIT, then `m_rvalid` the next cycle → no rvalid on either port, FSM in IDLE, a new `i_req` is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D always beats I.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   last_d,
    output owner_t owner,
    output logic   valid
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        valid = i_req | d_req;
        owner = OWN_I;
        if (i_req && d_req)
            owner = last_d ? OWN_I : OWN_D;
        else if (d_req)
            owner = OWN_D;
    end
`else
    logic unused_last_d;
    assign unused_last_d = last_d;

    always_comb begin
        valid = i_req | d_req;
        owner = d_req ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store ports onto one memory port, with a watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed D-over-I).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_req,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_we,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state;
    owner_t             own;
    logic [CNT_W-1:0]   tcnt;
    logic               last_d;
    logic               pick_valid;
    owner_t             pick_owner;
    logic               grant;
    logic               timeout;
    logic               done;
    logic               done_err;
    logic [DATA_W-1:0]  done_data;

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_d (last_d),
        .owner  (pick_owner),
        .valid  (pick_valid)
    );

    // Grants are the only combinational outputs; masked during reset.
    assign grant = !reset && (state == IDLE) && pick_valid;
    assign i_gnt = grant && (pick_owner == OWN_I);
    assign d_gnt = grant && (pick_owner == OWN_D);

    assign timeout = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A real completion or advance in the final cycle wins over the watchdog.
    always_comb begin
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        case (state)
            ISSUE: if (!m_ready && timeout) begin
                done     = 1'b1;
                done_err = 1'b1;
            end
            WAIT: begin
                if (m_rvalid) begin
                    done      = 1'b1;
                    done_data = m_rdata;
                end else if (timeout) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_d <= 1'b0;
        else if (grant)
            last_d <= (pick_owner == OWN_D);
    end
`else
    assign last_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            own      <= OWN_I;
            tcnt     <= '0;
            m_req    <= 1'b0;
            m_addr   <= '0;
            m_we     <= '0;
            m_wdata  <= '0;
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    own   <= pick_owner;
                    state <= ISSUE;
                    m_req <= 1'b1;
                    tcnt  <= '0;
                    if (pick_owner == OWN_D) begin
                        m_addr  <= d_addr;
                        m_we    <= d_we;
                        m_wdata <= d_wdata;
                    end else begin
                        m_addr  <= i_addr;
                        m_we    <= '0;
                        m_wdata <= '0;
                    end
                end
                ISSUE: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_ready) begin
                        m_req <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: tcnt <= tcnt + 1'b1;
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (done) begin
                state <= RESP;
                m_req <= 1'b0;
                if (own == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= done_data;
                    d_err    <= done_err;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= done_data;
                    i_err    <= done_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (TIMEOUT_CYCLES=8).
// Round-robin expectations apply when MEM_ARB_RR_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, m_ready, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_we;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        rst, ir, dr, mrdy, mrv;
        logic [31:0] ia, da, dwd, mrd;
        logic [3:0]  dwe;
        logic        eig, edg, eirv, edrv, eerr, emreq, all;
        logic [31:0] erd, emaddr, emwd;
        logic [3:0]  emwe;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic [31:0] ia,
        input logic dr, input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd,
        input logic mrdy, input logic mrv, input logic [31:0] mrd,
        input logic eig, input logic edg, input logic eirv, input logic edrv,
        input logic [31:0] erd, input logic eerr,
        input logic emreq, input logic [31:0] emaddr, input logic [3:0] emwe,
        input logic [31:0] emwd, input logic all);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dwe = dwe; v.dwd = dwd;
        v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
        v.eig = eig; v.edg = edg; v.eirv = eirv; v.edrv = edrv; v.erd = erd; v.eerr = eerr;
        v.emreq = emreq; v.emaddr = emaddr; v.emwe = emwe; v.emwd = emwd; v.all = all;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, compare 1 time unit later (well before the next rising edge).
    task automatic run(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_addr = v.da;
        d_we = v.dwe; d_wdata = v.dwd; m_ready = v.mrdy; m_rvalid = v.mrv; m_rdata = v.mrd;
        #1;
        chk({tag, ".i_gnt"},    32'(i_gnt),    32'(v.eig));
        chk({tag, ".d_gnt"},    32'(d_gnt),    32'(v.edg));
        chk({tag, ".i_rvalid"}, 32'(i_rvalid), 32'(v.eirv));
        chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(v.edrv));
        chk({tag, ".m_req"},    32'(m_req),    32'(v.emreq));
        if (v.emreq || v.all) begin
            chk({tag, ".m_addr"},  m_addr,      v.emaddr);
            chk({tag, ".m_we"},    32'(m_we),   32'(v.emwe));
            chk({tag, ".m_wdata"}, m_wdata,     v.emwd);
        end
        if (v.eirv || v.all) begin
            chk({tag, ".i_rdata"}, i_rdata,     v.erd);
            chk({tag, ".i_err"},   32'(i_err),  32'(v.eerr));
        end
        if (v.edrv || v.all) begin
            chk({tag, ".d_rdata"}, d_rdata,     v.erd);
            chk({tag, ".d_err"},   32'(d_err),  32'(v.eerr));
        end
    endtask

    vec_t tbl[19];

    initial begin
        //            rst ir ia    dr da        dwe   dwd           rdy rv mrd           ig dg irv drv erd          err mreq maddr     mwe   mwd           all
        tbl[0]  = mk(1, 1, 32'h40, 1, 32'h100, 4'hF, 32'h12345678, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        1);
        tbl[1]  = mk(1, 1, 32'h40, 1, 32'h100, 4'hF, 32'h12345678, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        1);
        tbl[2]  = mk(0, 1, 32'h40, 1, 32'h100, 4'hF, 32'h12345678, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[3]  = mk(0, 1, 32'h40, 0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h100,  4'hF, 32'h12345678, 0);
        tbl[4]  = mk(0, 1, 32'h40, 0, 32'h0,   4'h0, 32'h0,        0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[5]  = mk(0, 1, 32'h40, 0, 32'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[6]  = mk(0, 1, 32'h40, 0, 32'h0,   4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[7]  = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h40,   4'h0, 32'h0,        0);
        tbl[8]  = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[9]  = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[10] = mk(0, 0, 32'h0,  1, 32'h200, 4'h3, 32'hCAFEF00D, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[11] = mk(0, 0, 32'h0,  0, 32'hBAD, 4'hC, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h200,  4'h3, 32'hCAFEF00D, 0);
        tbl[12] = mk(0, 0, 32'h0,  0, 32'hBAD, 4'hC, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h200,  4'h3, 32'hCAFEF00D, 0);
        tbl[13] = mk(0, 0, 32'h0,  0, 32'hBAD, 4'hC, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h200,  4'h3, 32'hCAFEF00D, 0);
        tbl[14] = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h200,  4'h3, 32'hCAFEF00D, 0);
        tbl[15] = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[16] = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        0, 1, 32'h77,       0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[17] = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 32'h77,       0, 0, 32'h0,    4'h0, 32'h0,        0);
        tbl[18] = mk(0, 0, 32'h0,  0, 32'h0,   4'h0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0);

        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = '0; d_addr = '0;
        d_we = '0; d_wdata = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        @(posedge clk);

        foreach (tbl[k]) run(tbl[k], $sformatf("tbl%0d", k));

        // Watchdog: D load never accepted; ISSUE spans 8 cycles, error response next.
        run(mk(0, 0, 0, 1, 32'h300, 4'h0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "to_gnt");
        for (int k = 1; k <= 8; k++)
            run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 32'h300, 4'h0, 0, 0),
                $sformatf("to_issue%0d", k));
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h99,  0, 0, 0, 1, 32'h0, 1,  0, 0, 4'h0, 0, 0), "to_err");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h99,  0, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "to_late1");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "to_late2");

        // Reset in WAIT, stray completion afterwards, then a normal fetch.
        run(mk(0, 1, 32'h80, 0, 0, 4'h0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rw_gnt");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,       0, 0, 0, 0, 0, 0,  1, 32'h80, 4'h0, 0, 0), "rw_issue");
        run(mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rw_reset");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h55,  0, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 1), "rw_stray");
        run(mk(0, 1, 32'h84, 0, 0, 4'h0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rw_regnt");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,       0, 0, 0, 0, 0, 0,  1, 32'h84, 4'h0, 0, 0), "rw_issue2");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h11,  0, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rw_wait2");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,       0, 0, 1, 0, 32'h11, 0, 0, 0, 4'h0, 0, 0), "rw_resp2");

        // Back-to-back contention: first goes to D; second depends on arbitration mode.
        run(mk(0, 1, 32'hC0, 1, 32'h104, 4'h0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rr_c1");
        run(mk(0, 1, 32'hC0, 0, 0, 4'h0, 0, 1, 0, 0,        0, 0, 0, 0, 0, 0,  1, 32'h104, 4'h0, 0, 0), "rr_issue");
        run(mk(0, 1, 32'hC0, 0, 0, 4'h0, 0, 0, 1, 32'h22,   0, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rr_wait");
        run(mk(0, 1, 32'hC0, 0, 0, 4'h0, 0, 0, 0, 0,        0, 0, 0, 1, 32'h22, 0, 0, 0, 4'h0, 0, 0), "rr_resp");
`ifdef MEM_ARB_RR_EN
        run(mk(0, 1, 32'hC0, 1, 32'h108, 4'h0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rr_c2");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,             0, 0, 0, 0, 0, 0,  1, 32'hC0, 4'h0, 0, 0), "rr_issue2");
`else
        run(mk(0, 1, 32'hC0, 1, 32'h108, 4'h0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0), "rr_c2");
        run(mk(0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,             0, 0, 0, 0, 0, 0,  1, 32'h108, 4'h0, 0, 0), "rr_issue2");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
